// File: rtl/gshare_pkg.sv
// ----------------------------------------------------------------------------
// gshare_pkg
// Types and constants shared between the gshare predictor and its resolve
// queue: the in-flight entry record, the training request record, the 2-bit
// saturating counter encodings and a small direction-compare helper.
// ----------------------------------------------------------------------------
package gshare_pkg;

    // PC / global history width; the predictor and the resolve queue must agree.
    localparam int unsigned N = 7;

    // 2-bit saturating counter encodings used by the predictor table.
    localparam logic [1:0] SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] LNT = 2'b01;  // weakly not taken
    localparam logic [1:0] LT  = 2'b10;  // weakly taken
    localparam logic [1:0] ST  = 2'b11;  // strongly taken

    // One in-flight prediction, captured at issue time.
    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] history;
        logic         taken;
    } bp_entry_t;

    // Training request handed back to the predictor.
    typedef struct packed {
        logic         valid;
        logic         taken;
        logic         mispredicted;
        logic [N-1:0] history;
        logic [N-1:0] pc;
    } bp_train_t;

    localparam bp_train_t TRAIN_IDLE = '{
        valid:        1'b0,
        taken:        1'b0,
        mispredicted: 1'b0,
        history:      {N{1'b0}},
        pc:           {N{1'b0}}
    };

    // True when the resolved direction disagrees with the predicted one.
    function automatic logic dir_mismatch(input logic actual, input logic predicted);
        return actual ^ predicted;
    endfunction

endpackage

// File: rtl/bp_entry_fifo.sv
// ----------------------------------------------------------------------------
// bp_entry_fifo
// DEPTH x bp_entry_t register array with one synchronous write port and one
// asynchronous read port. No pointer logic lives here; the owner supplies the
// addresses. Contents are not reset (they are meaningless while empty).
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write slot
//   wr_data  in   entry to store
//   rd_addr  in   read slot
//   rd_data  out  entry currently stored at rd_addr
// ----------------------------------------------------------------------------
module bp_entry_fifo
    import gshare_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  bp_entry_t     wr_data,
    input  logic [AW-1:0] rd_addr,
    output bp_entry_t     rd_data
);

    bp_entry_t mem_q [DEPTH];
    bp_entry_t mem_d [DEPTH];

    // Next-state of the storage array: overwrite only the addressed slot.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage registers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/gshare_resolve_queue.sv
// ----------------------------------------------------------------------------
// gshare_resolve_queue
// In-order tracker for branches predicted by the gshare predictor. Each
// prediction is queued with its pc and history snapshot; each in-order
// resolution pops the oldest entry and, one cycle later, produces a
// registered training request. A mispredicted pop discards every younger
// (wrong-path) entry, including any allocation arriving in the same cycle.
// Ports:
//   clk, areset                     clock, async active-high reset
//   alloc_valid/pc/history/taken    new prediction from the predictor
//   alloc_ready                     queue not full (from current state only)
//   resolve_valid/taken             oldest branch resolved, actual direction
//   train_valid/taken/mispredicted/history/pc   registered training request
//   count                           occupied entries, 0..DEPTH
//   err                             sticky protocol error (overflow/underflow)
// ----------------------------------------------------------------------------
module gshare_resolve_queue
    import gshare_pkg::*;
#(
    parameter int unsigned N     = gshare_pkg::N,  // must match the package width
    parameter int unsigned DEPTH = 8               // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     alloc_valid,
    input  logic [N-1:0]             alloc_pc,
    input  logic [N-1:0]             alloc_history,
    input  logic                     alloc_taken,
    output logic                     alloc_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     train_valid,
    output logic                     train_taken,
    output logic                     train_mispredicted,
    output logic [N-1:0]             train_history,
    output logic [N-1:0]             train_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    // Pointers carry one wrap bit above the slot index.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        err_q, err_d;
    bp_train_t   train_q, train_d;

    logic        empty;
    logic        full;
    logic        pop;
    logic        mispredict;
    logic        push;
    bp_entry_t   wr_entry;
    bp_entry_t   rd_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Decisions are taken on the pre-edge state: a resolve never sees an
    // allocation from the same cycle, and a pop never frees room for it.
    assign pop        = resolve_valid && !empty;
    assign mispredict = pop && dir_mismatch(resolve_taken, rd_entry.taken);
    assign push       = alloc_valid && !full && !mispredict;

    assign wr_entry.pc      = alloc_pc;
    assign wr_entry.history = alloc_history;
    assign wr_entry.taken   = alloc_taken;

    bp_entry_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_entry)
    );

    // Pointer next-state; a mispredict collapses the write pointer onto the
    // post-pop read pointer, which drops all younger entries at once.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (mispredict) begin
            wr_ptr_d = rd_ptr_q + PTR_ONE;
        end else if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Sticky error: overflow (unless the alloc is wrong-path) or underflow.
    always_comb begin
        err_d = err_q
              | (alloc_valid && full && !mispredict)
              | (resolve_valid && empty);
    end

    // Training request: loaded on a pop, otherwise only the valid bit drops.
    always_comb begin
        train_d       = train_q;
        train_d.valid = 1'b0;
        if (pop) begin
            train_d.valid        = 1'b1;
            train_d.taken        = resolve_taken;
            train_d.mispredicted = mispredict;
            train_d.history      = rd_entry.history;
            train_d.pc           = rd_entry.pc;
        end else begin
            train_d.valid        = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            err_q    <= 1'b0;
            train_q  <= TRAIN_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            train_q  <= train_d;
        end
    end

    assign alloc_ready        = !full;
    assign count              = wr_ptr_q - rd_ptr_q;
    assign err                = err_q;
    assign train_valid        = train_q.valid;
    assign train_taken        = train_q.taken;
    assign train_mispredicted = train_q.mispredicted;
    assign train_history      = train_q.history;
    assign train_pc           = train_q.pc;

endmodule

// File: tb/tb_gshare_resolve_queue.sv
// ----------------------------------------------------------------------------
// Directed bench for gshare_resolve_queue (N=7, DEPTH=8).
// Inputs change 1 time unit after a rising edge; outputs are observed at the
// same point, i.e. they reflect the state registered at that edge.
// ----------------------------------------------------------------------------
module tb_gshare_resolve_queue;

    localparam int unsigned N     = 7;
    localparam int unsigned DEPTH = 8;

    logic         clk;
    logic         areset;
    logic         alloc_valid;
    logic [N-1:0] alloc_pc;
    logic [N-1:0] alloc_history;
    logic         alloc_taken;
    logic         alloc_ready;
    logic         resolve_valid;
    logic         resolve_taken;
    logic         train_valid;
    logic         train_taken;
    logic         train_mispredicted;
    logic [N-1:0] train_history;
    logic [N-1:0] train_pc;
    logic [3:0]   count;
    logic         err;

    int errors = 0;
    int checks = 0;

    gshare_resolve_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .areset             (areset),
        .alloc_valid        (alloc_valid),
        .alloc_pc           (alloc_pc),
        .alloc_history      (alloc_history),
        .alloc_taken        (alloc_taken),
        .alloc_ready        (alloc_ready),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_history      (train_history),
        .train_pc           (train_pc),
        .count              (count),
        .err                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid   = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic set_alloc(input logic [N-1:0] pc, input logic [N-1:0] hist, input logic tk);
        alloc_valid   = 1'b1;
        alloc_pc      = pc;
        alloc_history = hist;
        alloc_taken   = tk;
    endtask

    task automatic do_reset();
        idle();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();
    endtask

    // Payload generators for the wrap test.
    function automatic logic [N-1:0] f_pc(input int i);
        return 7'(i * 5 + 3);
    endfunction
    function automatic logic [N-1:0] f_hist(input int i);
        return 7'(i * 7 + 1);
    endfunction
    function automatic logic f_tk(input int i);
        return (i % 3) == 0;
    endfunction

    initial begin
        areset        = 1'b1;
        alloc_valid   = 1'b0;
        alloc_pc      = 7'h00;
        alloc_history = 7'h00;
        alloc_taken   = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;

        // 1. reset then idle
        tick();
        tick();
        areset = 1'b0;
        tick();
        tick();
        check("rst_count",  32'(count), 32'd0);
        check("rst_ready",  32'(alloc_ready), 32'd1);
        check("rst_tvalid", 32'(train_valid), 32'd0);
        check("rst_err",    32'(err), 32'd0);
        check("rst_tpc",    32'(train_pc), 32'd0);

        // 2. single alloc then correct resolve
        set_alloc(7'h05, 7'h12, 1'b1);
        tick();
        check("t2_count1", 32'(count), 32'd1);
        idle();
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        tick();
        check("t2_tvalid", 32'(train_valid), 32'd1);
        check("t2_tpc",    32'(train_pc), 32'h05);
        check("t2_thist",  32'(train_history), 32'h12);
        check("t2_ttaken", 32'(train_taken), 32'd1);
        check("t2_tmis",   32'(train_mispredicted), 32'd0);
        check("t2_count0", 32'(count), 32'd0);
        idle();
        tick();
        check("t2_tvalid_drop", 32'(train_valid), 32'd0);
        check("t2_tpc_hold",    32'(train_pc), 32'h05);

        // 3. fill, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            set_alloc(7'(16 + i), 7'(i * 3 + 1), 1'(i & 1));
            tick();
            check("t3_fill_count", 32'(count), 32'(i + 1));
        end
        check("t3_full_ready", 32'(alloc_ready), 32'd0);
        check("t3_full_err",   32'(err), 32'd0);
        set_alloc(7'h7F, 7'h7F, 1'b1);
        tick();
        check("t3_ovf_err",   32'(err), 32'd1);
        check("t3_ovf_count", 32'(count), 32'd8);
        idle();
        for (int i = 0; i < 8; i++) begin
            resolve_valid = 1'b1;
            resolve_taken = 1'(i & 1);
            tick();
            check("t3_tvalid", 32'(train_valid), 32'd1);
            check("t3_tpc",    32'(train_pc), 32'(16 + i));
            check("t3_thist",  32'(train_history), 32'(7'(i * 3 + 1)));
            check("t3_tmis",   32'(train_mispredicted), 32'd0);
            check("t3_count",  32'(count), 32'(7 - i));
        end
        idle();
        tick();
        check("t3_empty_ready", 32'(alloc_ready), 32'd1);
        check("t3_err_sticky",  32'(err), 32'd1);

        // 4. mispredict flush with concurrent (wrong-path) alloc
        do_reset();
        check("t4_err_cleared", 32'(err), 32'd0);
        set_alloc(7'h20, 7'h01, 1'b0);
        tick();
        set_alloc(7'h21, 7'h02, 1'b1);
        tick();
        set_alloc(7'h22, 7'h03, 1'b1);
        tick();
        check("t4_count3", 32'(count), 32'd3);
        set_alloc(7'h30, 7'h30, 1'b1);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        tick();
        check("t4_tvalid", 32'(train_valid), 32'd1);
        check("t4_tmis",   32'(train_mispredicted), 32'd1);
        check("t4_ttaken", 32'(train_taken), 32'd1);
        check("t4_tpc",    32'(train_pc), 32'h20);
        check("t4_count",  32'(count), 32'd0);
        check("t4_err",    32'(err), 32'd0);
        idle();
        tick();
        check("t4_count_idle", 32'(count), 32'd0);
        set_alloc(7'h40, 7'h44, 1'b0);
        tick();
        idle();
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        tick();
        check("t4_next_tpc",  32'(train_pc), 32'h40);
        check("t4_next_thist", 32'(train_history), 32'h44);
        check("t4_next_tmis", 32'(train_mispredicted), 32'd0);

        // 5. resolve while empty (with concurrent alloc: no bypass)
        set_alloc(7'h50, 7'h55, 1'b0);
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        tick();
        check("t5_uf_tvalid", 32'(train_valid), 32'd0);
        check("t5_uf_err",    32'(err), 32'd1);
        check("t5_uf_count",  32'(count), 32'd1);
        check("t5_uf_tpc",    32'(train_pc), 32'h40);
        // pop 0x50 while allocating the first wrap-test entry
        set_alloc(f_pc(0), f_hist(0), f_tk(0));
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        tick();
        check("t5_p_tpc",   32'(train_pc), 32'h50);
        check("t5_p_count", 32'(count), 32'd1);
        // 20 overlapping resolve/alloc pairs, wrapping the pointers
        for (int i = 0; i < 20; i++) begin
            if (i < 19) begin
                set_alloc(f_pc(i + 1), f_hist(i + 1), f_tk(i + 1));
            end else begin
                alloc_valid = 1'b0;
            end
            resolve_valid = 1'b1;
            resolve_taken = f_tk(i);
            tick();
            check("t5_w_tvalid", 32'(train_valid), 32'd1);
            check("t5_w_tpc",    32'(train_pc), 32'(f_pc(i)));
            check("t5_w_thist",  32'(train_history), 32'(f_hist(i)));
            check("t5_w_ttaken", 32'(train_taken), 32'(f_tk(i)));
            check("t5_w_tmis",   32'(train_mispredicted), 32'd0);
            check("t5_w_count",  32'(count), (i < 19) ? 32'd1 : 32'd0);
        end
        idle();
        tick();

        // 6. async reset mid-stream with count=5
        for (int i = 0; i < 6; i++) begin
            set_alloc(7'(8'h10 + i), 7'(i), 1'b1);
            tick();
        end
        idle();
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        tick();
        check("t6_count5", 32'(count), 32'd5);
        check("t6_tvalid", 32'(train_valid), 32'd1);
        areset = 1'b1;
        #1;
        check("t6_async_count", 32'(count), 32'd0);
        tick();
        check("t6_rst_count",  32'(count), 32'd0);
        check("t6_rst_tvalid", 32'(train_valid), 32'd0);
        check("t6_rst_err",    32'(err), 32'd0);
        check("t6_rst_ready",  32'(alloc_ready), 32'd1);
        areset = 1'b0;
        idle();
        tick();
        set_alloc(7'h66, 7'h2A, 1'b0);
        tick();
        idle();
        check("t6_slot0_pc", 32'(dut.u_fifo.mem_q[0].pc), 32'h66);
        check("t6_count1",   32'(count), 32'd1);
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        tick();
        check("t6_tpc",   32'(train_pc), 32'h66);
        check("t6_thist", 32'(train_history), 32'h2A);
        check("t6_tmis",  32'(train_mispredicted), 32'd0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
